board_renderer: RTL and testbench
=================================

Name: board_renderer

Overview:
- Reader side of the game board memory.
- Takes a snapshot of the packed 8x8 board vector that the game datapath writes, plus the current cursor position.
- Walks all 64 cells and emits one VGA-adapter pixel write per cycle: team-coloured squares, then a cursor outline.
- Sits between the game datapath and the 160x120 VGA adapter. The top-level control FSM pulses start once per move.

Parameters:
- SQ_SIZE, 14: pixels per square edge; must be >= 12.
- ORIGIN_X, 8: screen x of the board's left edge.
- ORIGIN_Y, 4: screen y of the board's top edge.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- board  in  385  packed board; cell (cx,cy) is at bits [(cx+cy*8)*6 +: 6]; bit 384 ignored
- cursor_x  in  3  cursor column
- cursor_y  in  3  cursor row
- start  in  1  one-cycle request to redraw the board
- x  out  8  pixel x to the VGA adapter
- y  out  7  pixel y to the VGA adapter
- colour  out  3  pixel colour {R,G,B}
- plot  out  1  pixel write strobe
- busy  out  1  high while rendering
- done  out  1  one-cycle pulse when a frame is complete

Behaviour:
- Reset (asynchronous, any state, including mid-frame) forces:
  - state IDLE;
  - x=0, y=0, colour=0;
  - plot=0, busy=0, done=0;
  - all counters 0.
- States: IDLE, FETCH, FILL, CURSOR, DONE.
- IDLE:
  - start=1 latches board, cursor_x and cursor_y into internal snapshot registers, clears the cell index, and moves to FETCH.
  - Inputs changing after that edge do not affect the frame.
- FETCH (1 cycle, plot=0):
  - Loads the 6-bit code for cell index i (cx=i%8, cy=i/8) from the snapshot.
  - Computes the fill colour: 000000 -> 3'b000 black; 111111 -> 3'b010 green (lake); bit5=0 -> 3'b100 red; bit5=1 -> 3'b001 blue.
  - Clears px and py; moves to FILL.
- FILL (SQ_SIZE*SQ_SIZE cycles, plot=1 every cycle):
  - x = ORIGIN_X + cx*SQ_SIZE + px; y = ORIGIN_Y + cy*SQ_SIZE + py.
  - px increments every cycle; when px wraps to 0, py increments (row-major scan).
  - After the last pixel (px=py=SQ_SIZE-1): if i=63, go to CURSOR with px=py=0; otherwise increment i and go to FETCH.
- CURSOR (SQ_SIZE*SQ_SIZE cycles):
  - Scans the snapshot cursor square with the same px/py order.
  - plot=1 only on border pixels (px or py equal to 0 or SQ_SIZE-1); colour=3'b110 yellow.
  - Then goes to DONE.
- DONE (1 cycle): done=1, then IDLE.
- busy=1 in every state except IDLE.
- start is ignored while busy=1. start in the DONE cycle is also ignored.
- x and y are computed at full output width. ORIGIN plus board size must not exceed 160x120; wrap behaviour beyond that is undefined.
- Frame latency from the start edge to the done pulse is 64*(1+SQ_SIZE^2) + SQ_SIZE^2 + 1 cycles. For SQ_SIZE=14 this is 12805 cycles.
- Cursor outline pixel count is 4*(SQ_SIZE-1); 52 for SQ_SIZE=14.

Optional Feature:
- Macro: BOARD_RENDERER_GLYPH_EN.
- When defined:
  - During FILL, a 3x5 glyph scaled 2x (6x10 region) is overlaid at square offset gx=(SQ_SIZE-6)/2, gy=(SQ_SIZE-10)/2.
  - Pixels whose glyph bit is 1 are drawn in 3'b111 white instead of the fill colour.
  - Glyph source is the low 5 bits of the cell code; font rows are listed MSB = left column.
  - F(00001) = 111,100,110,100,100
  - B(00010) = 110,101,110,101,110
  - S(00011) = 111,100,111,001,111
  - 2(00100) = 111,001,111,100,111
  - 3(00101) = 111,001,111,001,111
  - 9(00110) = 111,101,111,001,111
  - 10(00111) = 111,101,101,101,111
  - All other codes have no glyph.
- When not defined: squares are solid fill colour. Timing is identical either way.

Test Plan:
- Reset all-zero board, pulse start at cycle 0 -> done pulses exactly 12805 cycles later; every FILL pixel colour=000; CURSOR plots exactly 52 pixels.
- Cell (0,0)=100001 and cell (7,7)=000100 -> pixels (8..21, 4..17) are colour 001; pixels (106..119, 102..115) are colour 100.
- Cell (3,4)=111111 with cursor=(3,4) -> that square is filled 010; yellow border plotted at x=50 and x=63 for y=60..73.
- Assert start again at cycle 100 mid-frame, and change board at cycle 50 -> no restart; rendered colours match the snapshot taken at cycle 0.
- Assert reset at cycle 5000 -> plot, busy and done drop immediately; a new start renders a full frame normally.
- With BOARD_RENDERER_GLYPH_EN defined, cell (0,0)=000001 (red F) -> pixel (ORIGIN_X+4, ORIGIN_Y+2)=(12,6) is white 111; pixel (16,8) is red 100.

Source files
------------

// File: rtl/board_renderer.sv
// Board renderer: snapshots the packed 8x8 board and cursor, then streams one
// VGA pixel write per cycle (filled squares, then a yellow cursor outline).
// Optional cell glyph overlay is enabled by defining BOARD_RENDERER_GLYPH_EN.
module board_renderer #(
  parameter int unsigned SQ_SIZE  = 14,
  parameter int unsigned ORIGIN_X = 8,
  parameter int unsigned ORIGIN_Y = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [384:0] board,
  input  logic [2:0]   cursor_x,
  input  logic [2:0]   cursor_y,
  input  logic         start,
  output logic [7:0]   x,
  output logic [6:0]   y,
  output logic [2:0]   colour,
  output logic         plot,
  output logic         busy,
  output logic         done
);

  localparam int unsigned PW     = $clog2(SQ_SIZE);
  localparam int unsigned CELL_W = 6;
  localparam int unsigned SNAP_W = 64 * CELL_W;
  localparam logic [PW-1:0] LAST = PW'(SQ_SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FILL, S_CURSOR, S_DONE} state_t;

  state_t state_q, state_d;

  logic [SNAP_W-1:0] snap_q, snap_d;
  logic [2:0]        cx_q, cx_d, cy_q, cy_d;
  logic [5:0]        idx_q, idx_d;
  logic [PW-1:0]     px_q, px_d, py_q, py_d;
  logic [2:0]        fill_q, fill_d;
  logic [7:0]        x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic [2:0]        colour_q, colour_d;
  logic              plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic       board_unused;
  logic       last_px, last_py, last_pix, border;
  logic [5:0] cell_code;
  logic [2:0] sq_x, sq_y;

  assign board_unused = board[384];
  assign last_px   = (px_q == LAST);
  assign last_py   = (py_q == LAST);
  assign last_pix  = last_px && last_py;
  assign border    = (px_q == '0) || (py_q == '0) || last_px || last_py;
  assign cell_code = snap_q[9'(idx_q) * 9'(CELL_W) +: CELL_W];
  assign sq_x      = (state_q == S_CURSOR) ? cx_q : idx_q[2:0];
  assign sq_y      = (state_q == S_CURSOR) ? cy_q : idx_q[5:3];

  function automatic logic [2:0] fill_colour(input logic [5:0] code);
    logic [2:0] c;
    if (code == 6'b000000)      c = 3'b000;
    else if (code == 6'b111111) c = 3'b010;
    else if (code[5])           c = 3'b001;
    else                        c = 3'b100;
    return c;
  endfunction

`ifdef BOARD_RENDERER_GLYPH_EN
  localparam int unsigned GX = (SQ_SIZE - 6) / 2;
  localparam int unsigned GY = (SQ_SIZE - 10) / 2;

  // 3x5 font, rows top to bottom, MSB of each row is the left column
  function automatic logic [2:0] glyph_row(input logic [4:0] g, input logic [2:0] r);
    logic [14:0] f;
    logic [2:0]  row;
    case (g)
      5'd1:    f = 15'b111_100_110_100_100;
      5'd2:    f = 15'b110_101_110_101_110;
      5'd3:    f = 15'b111_100_111_001_111;
      5'd4:    f = 15'b111_001_111_100_111;
      5'd5:    f = 15'b111_001_111_001_111;
      5'd6:    f = 15'b111_101_111_001_111;
      5'd7:    f = 15'b111_101_101_101_111;
      default: f = 15'b0;
    endcase
    case (r)
      3'd0:    row = f[14:12];
      3'd1:    row = f[11:9];
      3'd2:    row = f[8:6];
      3'd3:    row = f[5:3];
      default: row = f[2:0];
    endcase
    return row;
  endfunction

  logic       glyph_hit;
  logic [1:0] gcol;
  logic [2:0] grow;

  always_comb begin
    gcol = 2'((px_q - PW'(GX)) >> 1);
    grow = glyph_row(cell_code[4:0], 3'((py_q - PW'(GY)) >> 1));
    glyph_hit = (px_q >= PW'(GX)) && (px_q < PW'(GX + 6)) &&
                (py_q >= PW'(GY)) && (py_q < PW'(GY + 10)) &&
                grow[2'd2 - gcol];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_FILL;
      S_FILL:   if (last_pix) state_d = (idx_q == 6'd63) ? S_CURSOR : S_FETCH;
      S_CURSOR: if (last_pix) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered one stage behind the scan counters
  always_comb begin
    snap_d   = snap_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    idx_d    = idx_q;
    px_d     = px_q;
    py_d     = py_q;
    fill_d   = fill_q;
    x_d      = '0;
    y_d      = '0;
    colour_d = '0;
    plot_d   = 1'b0;
    busy_d   = (state_q != S_IDLE);
    done_d   = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d = board[SNAP_W-1:0];
          cx_d   = cursor_x;
          cy_d   = cursor_y;
          idx_d  = '0;
        end
      end
      S_FETCH: begin
        fill_d = fill_colour(cell_code);
        px_d   = '0;
        py_d   = '0;
      end
      S_FILL, S_CURSOR: begin
        x_d = 8'(ORIGIN_X) + 8'(sq_x) * 8'(SQ_SIZE) + 8'(px_q);
        y_d = 7'(ORIGIN_Y) + 7'(sq_y) * 7'(SQ_SIZE) + 7'(py_q);
        if (state_q == S_FILL) begin
          plot_d   = 1'b1;
          colour_d = fill_q;
`ifdef BOARD_RENDERER_GLYPH_EN
          if (glyph_hit) colour_d = 3'b111;
`endif
          if (last_pix && (idx_q != 6'd63)) idx_d = idx_q + 6'd1;
        end else begin
          plot_d   = border;
          colour_d = 3'b110;
        end
        if (last_px) begin
          px_d = '0;
          py_d = last_py ? '0 : py_q + PW'(1);
        end else begin
          px_d = px_q + PW'(1);
        end
      end
      S_DONE:  idx_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q   <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      idx_q    <= '0;
      px_q     <= '0;
      py_q     <= '0;
      fill_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      snap_q   <= snap_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      idx_q    <= idx_d;
      px_q     <= px_d;
      py_q     <= py_d;
      fill_q   <= fill_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_board_renderer.sv
// Bench for board_renderer: random boards rendered against a pixel-list model
// and a captured frame buffer, with directed mid-frame start/board/reset cases.
module tb_board_renderer;

  localparam int SQ      = 14;
  localparam int OX      = 8;
  localparam int OY      = 4;
  localparam int LATENCY = 64 * (1 + SQ * SQ) + SQ * SQ + 1;
  localparam int NPLOTS  = 64 * SQ * SQ + 4 * (SQ - 1);
  localparam int GX      = (SQ - 6) / 2;
  localparam int GY      = (SQ - 10) / 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [384:0] board;
  logic [2:0]   cursor_x, cursor_y;
  logic         start;
  logic [7:0]   x;
  logic [6:0]   y;
  logic [2:0]   colour;
  logic         plot, busy, done;

  board_renderer #(.SQ_SIZE(SQ), .ORIGIN_X(OX), .ORIGIN_Y(OY)) dut (
    .clk(clk), .reset(reset), .board(board), .cursor_x(cursor_x),
    .cursor_y(cursor_y), .start(start), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;

  pix_t       expq[$];
  logic [2:0] fb [0:159][0:119];
  int total = 0;
  int bad   = 0;
  int lat, nplot, nyel, nbadpix;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] font(input logic [4:0] g);
    case (g)
      5'd1: return 15'b111100110100100;
      5'd2: return 15'b110101110101110;
      5'd3: return 15'b111100111001111;
      5'd4: return 15'b111001111100111;
      5'd5: return 15'b111001111001111;
      5'd6: return 15'b111101111001111;
      5'd7: return 15'b111101101101111;
      default: return 15'b0;
    endcase
  endfunction

  function automatic bit glyph_zone(input int px, input int py);
`ifdef BOARD_RENDERER_GLYPH_EN
    return (px >= GX) && (px < GX + 6) && (py >= GY) && (py < GY + 10);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2:0] model_pix(input logic [5:0] code, input int px, input int py);
    logic [2:0]  c;
    logic [14:0] f;
    if (code == 6'd0)       c = 3'b000;
    else if (code == 6'd63) c = 3'b010;
    else if (code[5])       c = 3'b001;
    else                    c = 3'b100;
    f = font(code[4:0]);
    if (glyph_zone(px, py) && f[14 - 3 * ((py - GY) / 2) - (px - GX) / 2]) c = 3'b111;
    return c;
  endfunction

  task automatic build_model(input logic [383:0] b, input int cx, input int cy);
    expq.delete();
    for (int i = 0; i < 64; i++)
      for (int py = 0; py < SQ; py++)
        for (int px = 0; px < SQ; px++)
          expq.push_back('{8'(OX + (i % 8) * SQ + px), 7'(OY + (i / 8) * SQ + py),
                           model_pix(b[i*6 +: 6], px, py)});
    for (int py = 0; py < SQ; py++)
      for (int px = 0; px < SQ; px++)
        if (px == 0 || py == 0 || px == SQ - 1 || py == SQ - 1)
          expq.push_back('{8'(OX + cx * SQ + px), 7'(OY + cy * SQ + py), 3'b110});
  endtask

  function automatic logic [384:0] rand_board();
    logic [384:0] b;
    int r;
    b = '0;
    for (int i = 0; i < 64; i++) begin
      r = $urandom_range(0, 7);
      if (r == 0)      b[i*6 +: 6] = 6'd0;
      else if (r == 1) b[i*6 +: 6] = 6'd63;
      else             b[i*6 +: 6] = 6'($urandom);
    end
    b[384] = 1'($urandom);
    return b;
  endfunction

  // Pulse start, then capture plotted pixels until done, a bound, or a reset
  task automatic run_frame(input int chg_at, input int restart_at, input int reset_at);
    lat = -1; nplot = 0; nyel = 0; nbadpix = 0;
    for (int i = 0; i < 160; i++)
      for (int j = 0; j < 120; j++) fb[i][j] = 3'bxxx;
    build_model(board[383:0], int'(cursor_x), int'(cursor_y));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= LATENCY + 200; k++) begin
      @(posedge clk); #1;
      if (plot) begin
        nplot++;
        if (colour == 3'b110) nyel++;
        if (x < 160 && y < 120) fb[x][y] = colour;
        if (expq.size() == 0 || {x, y, colour} !== expq[0]) nbadpix++;
        if (expq.size() > 0) void'(expq.pop_front());
      end
      if (done) begin
        lat = k;
        break;
      end
      if (k == 2000) check("busy_mid_frame", busy, 1);
      if (k == chg_at) begin
        board    = rand_board();
        cursor_x = 3'($urandom);
        cursor_y = 3'($urandom);
      end
      start = (k == restart_at);
      if (k == reset_at) begin
        reset = 1'b1;
        #1;
        check("reset_plot", plot, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        #1 reset = 1'b0;
        lat = -2;
        break;
      end
    end
    start = 1'b0;
  endtask

  int nb;

  initial begin
    reset = 1'b1; start = 1'b0; board = '0; cursor_x = '0; cursor_y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // all-zero board
    cursor_x = 3'($urandom); cursor_y = 3'($urandom);
    run_frame(-1, -1, -1);
    check("f1_latency", lat, LATENCY);
    check("f1_plots", nplot, NPLOTS);
    check("f1_cursor_plots", nyel, 4 * (SQ - 1));
    check("f1_pixels", nbadpix, 0);
    @(posedge clk); #1;
    check("f1_done_pulse", done, 0);
    check("f1_busy_after", busy, 0);

    // blue corner cell (0,0), red corner cell (7,7)
    board = rand_board();
    board[5:0] = 6'b100001;
    board[383:378] = 6'b000100;
    cursor_x = 3'd3; cursor_y = 3'd3;
    run_frame(-1, -1, -1);
    check("f2_latency", lat, LATENCY);
    check("f2_pixels", nbadpix, 0);
    nb = 0;
    for (int i = 8; i <= 21; i++)
      for (int j = 4; j <= 17; j++)
        if (!glyph_zone(i - 8, j - 4) && fb[i][j] !== 3'b001) nb++;
    check("f2_blue_square", nb, 0);
    nb = 0;
    for (int i = 106; i <= 119; i++)
      for (int j = 102; j <= 115; j++)
        if (!glyph_zone(i - 106, j - 102) && fb[i][j] !== 3'b100) nb++;
    check("f2_red_square", nb, 0);

    // lake under cursor, board change at 50 and restart attempt at 100
    board = rand_board();
    board[215:210] = 6'b111111;
    cursor_x = 3'd3; cursor_y = 3'd4;
    run_frame(50, 100, -1);
    check("f3_latency", lat, LATENCY);
    check("f3_pixels", nbadpix, 0);
    check("f3_cursor_plots", nyel, 4 * (SQ - 1));
    nb = 0;
    for (int i = 51; i <= 62; i++)
      for (int j = 61; j <= 72; j++)
        if (fb[i][j] !== 3'b010) nb++;
    check("f3_lake_interior", nb, 0);
    nb = 0;
    for (int j = 60; j <= 73; j++) begin
      if (fb[50][j] !== 3'b110) nb++;
      if (fb[63][j] !== 3'b110) nb++;
    end
    check("f3_cursor_sides", nb, 0);

    // reset in mid-frame
    board = rand_board();
    cursor_x = 3'($urandom); cursor_y = 3'($urandom);
    run_frame(-1, -1, 5000);
    check("f4_reset_taken", lat, -2);
    @(posedge clk); #1;
    check("f4_idle_busy", busy, 0);
    check("f4_idle_plot", plot, 0);

    // full frame after reset; cell (0,0) red F
    board = rand_board();
    board[5:0] = 6'b000001;
    cursor_x = 3'($urandom); cursor_y = 3'($urandom);
    run_frame(-1, -1, -1);
    check("f5_latency", lat, LATENCY);
    check("f5_plots", nplot, NPLOTS);
    check("f5_pixels", nbadpix, 0);
`ifdef BOARD_RENDERER_GLYPH_EN
    check("f5_glyph_on", fb[12][6], 3'b111);
`else
    check("f5_glyph_on", fb[12][6], 3'b100);
`endif
    check("f5_glyph_off", fb[16][8], 3'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
